// File: rtl/tetris_pkg.sv
// tetris_pkg: board size defaults, piece codes, checker FSM states and the cell address helper
package tetris_pkg;
  localparam int DEF_BOARD_W = 10;
  localparam int DEF_BOARD_H = 22;
  typedef enum logic [2:0] {PIECE_O, PIECE_I, PIECE_L, PIECE_J, PIECE_S, PIECE_Z, PIECE_T} piece_t;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DRAIN, S_WRITE, S_DONE} state_t;
  function automatic int unsigned cell_addr(input int unsigned y, input int unsigned x, input int unsigned w);
    return y * w + x;
  endfunction
endpackage

// File: rtl/board_cell_addr.sv
// board_cell_addr: (y,x) -> board RAM address y*BOARD_W+x and in_bounds flag (y<BOARD_H, x<BOARD_W)
module board_cell_addr
  import tetris_pkg::*;
#(
  parameter int BOARD_W = DEF_BOARD_W,
  parameter int BOARD_H = DEF_BOARD_H,
  parameter int ADDR_W  = 8
) (
  input  logic [4:0]        y,
  input  logic [3:0]        x,
  output logic [ADDR_W-1:0] addr,
  output logic              in_bounds
);
  always_comb begin
    addr      = ADDR_W'(cell_addr(32'(y), 32'(x), BOARD_W));
    in_bounds = (32'(y) < BOARD_H) && (32'(x) < BOARD_W);
  end
endmodule

// File: rtl/piece_cell_checker.sv
// piece_cell_checker: bounds/occupancy check and optional lock of four piece cells into board RAM (req_valid/req_ready/req_lock/y1..y4/x1..x4 in; done/collide/oob/locked out; mem_addr/mem_rd_en/mem_rd_data/mem_wr_en/mem_wr_data RAM port; PIECE_CHECKER_COLOR_EN adds req_type and 3-bit cell data)
module piece_cell_checker
  import tetris_pkg::*;
#(
  parameter int BOARD_W = DEF_BOARD_W,
  parameter int BOARD_H = DEF_BOARD_H,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_lock,
`ifdef PIECE_CHECKER_COLOR_EN
  input  logic [2:0]        req_type,
`endif
  input  logic [4:0]        y1,
  input  logic [4:0]        y2,
  input  logic [4:0]        y3,
  input  logic [4:0]        y4,
  input  logic [3:0]        x1,
  input  logic [3:0]        x2,
  input  logic [3:0]        x3,
  input  logic [3:0]        x4,
  output logic              done,
  output logic              collide,
  output logic              oob,
  output logic              locked,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
`ifdef PIECE_CHECKER_COLOR_EN
  input  logic [2:0]        mem_rd_data,
  output logic [2:0]        mem_wr_data
`else
  input  logic              mem_rd_data,
  output logic              mem_wr_data
`endif
);
  state_t state, state_n;
  logic [1:0] idx;
  logic [4:0] ys [4];
  logic [3:0] xs [4];
  logic lock_q, rd_pend, in_b, collide_n, accept;
  logic [ADDR_W-1:0] addr;
`ifdef PIECE_CHECKER_COLOR_EN
  logic [2:0] type_q;
`endif
  board_cell_addr #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .ADDR_W(ADDR_W)) u_addr (
    .y(ys[idx]),
    .x(xs[idx]),
    .addr(addr),
    .in_bounds(in_b)
  );
  // reset gates the strobes combinationally so an abort mid-WRITE issues no further writes
  always_comb begin
    req_ready = state == S_IDLE;
    accept    = req_valid && req_ready;
    done      = state == S_DONE;
    collide_n = collide | (rd_pend & (|mem_rd_data));
    mem_rd_en = !reset && state == S_CHECK && in_b;
    mem_wr_en = !reset && state == S_WRITE;
    mem_addr  = (state == S_CHECK || state == S_WRITE) ? addr : '0;
`ifdef PIECE_CHECKER_COLOR_EN
    mem_wr_data = mem_wr_en ? type_q + 3'd1 : 3'd0;
`else
    mem_wr_data = mem_wr_en;
`endif
    case (state)
      S_IDLE:  state_n = req_valid ? S_CHECK : S_IDLE;
      S_CHECK: state_n = &idx ? S_DRAIN : S_CHECK;
      S_DRAIN: state_n = (lock_q && !collide_n && !oob) ? S_WRITE : S_DONE;
      S_WRITE: state_n = &idx ? S_DONE : S_WRITE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= 2'd0;
      lock_q  <= 1'b0;
      rd_pend <= 1'b0;
      collide <= 1'b0;
      oob     <= 1'b0;
      locked  <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= (state == S_CHECK || state == S_WRITE) ? idx + 2'd1 : 2'd0;
      rd_pend <= mem_rd_en;
      collide <= accept ? 1'b0 : collide_n;
      oob     <= accept ? 1'b0 : oob | (state == S_CHECK && !in_b);
      locked  <= accept ? 1'b0 : locked | (state == S_WRITE && &idx);
      if (accept) begin
        ys     <= '{y1, y2, y3, y4};
        xs     <= '{x1, x2, x3, x4};
        lock_q <= req_lock;
`ifdef PIECE_CHECKER_COLOR_EN
        type_q <= req_type;
`endif
      end
    end
  end
endmodule
